// File: rtl/mul_unit.sv
// mul_unit: pipelined signed multiply feeding the ROB write port.
// Optional overflow exception via MUL_OVERFLOW_XCPT_EN.
package mul_unit_pkg;
    localparam int XCPT_ADDR_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [XCPT_ADDR_W-1:0] addr_val;
    } fetch_xcpt_t;

    typedef struct packed {
        logic                   valid;
        logic [XCPT_ADDR_W-1:0] addr_val;
    } decode_xcpt_t;

    typedef struct packed {
        logic                   xcpt_overflow;
        logic [XCPT_ADDR_W-1:0] addr_val;
    } mul_xcpt_t;
endpackage

module mul_stage #(
    parameter int W = 1
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    assign q = d;
endmodule

module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int DATA_W     = 32,
    parameter int ROB_ID_W   = 3,
    parameter int PC_W       = 32,
    parameter int RF_ADDR_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_valid_in,
    input  logic [ROB_ID_W-1:0]  instr_id_in,
    input  logic [PC_W-1:0]      program_counter_in,
    input  logic [RF_ADDR_W-1:0] dest_reg_in,
    input  logic [DATA_W-1:0]    src1_data_in,
    input  logic [DATA_W-1:0]    src2_data_in,
    input  fetch_xcpt_t          xcpt_fetch_in,
    input  decode_xcpt_t         xcpt_decode_in,
    input  logic                 stall_in,
    input  logic                 flush_in,
    output logic                 ready_out,
    output logic                 instr_valid_out,
    output logic [ROB_ID_W-1:0]  instr_id_out,
    output logic [PC_W-1:0]      program_counter_out,
    output logic [RF_ADDR_W-1:0] dest_reg_out,
    output logic [DATA_W-1:0]    data_result_out,
    output fetch_xcpt_t          xcpt_fetch_out,
    output decode_xcpt_t         xcpt_decode_out,
    output mul_xcpt_t            xcpt_mul_out
);
    typedef struct packed {
        logic                 valid;
        logic [ROB_ID_W-1:0]  id;
        logic [PC_W-1:0]      pc;
        logic [RF_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]    data;
        fetch_xcpt_t          xf;
        decode_xcpt_t         xd;
        mul_xcpt_t            xm;
    } stage_t;

    localparam int SW = $bits(stage_t);

    stage_t head;
    stage_t pre [NUM_STAGES];
    stage_t nxt [NUM_STAGES];
    stage_t stg [NUM_STAGES];

    logic xcpt_any;
    assign xcpt_any = xcpt_fetch_in.valid | xcpt_decode_in.valid;

`ifdef MUL_OVERFLOW_XCPT_EN
    logic signed [2*DATA_W-1:0] prod;
    logic        [DATA_W:0]     prod_hi;
    logic                       ovf;

    assign prod = $signed(src1_data_in) * $signed(src2_data_in);
    assign prod_hi = prod[2*DATA_W-1:DATA_W-1];
    // Upper half plus sign bit must be a pure sign extension
    assign ovf = (|prod_hi) & ~(&prod_hi);
`else
    logic [DATA_W-1:0] prod_lo;

    assign prod_lo = src1_data_in * src2_data_in;
`endif

    always_comb begin
        head       = '0;
        head.valid = instr_valid_in;
        head.id    = instr_id_in;
        head.pc    = program_counter_in;
        head.rd    = dest_reg_in;
        head.xf    = xcpt_fetch_in;
        head.xd    = xcpt_decode_in;
`ifdef MUL_OVERFLOW_XCPT_EN
        head.data             = prod[DATA_W-1:0];
        head.xm.xcpt_overflow = ovf & ~xcpt_any;
        head.xm.addr_val      = XCPT_ADDR_W'(program_counter_in);
`else
        head.data = prod_lo;
`endif
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign pre[g] = head;
        end else begin : g_rest
            assign pre[g] = stg[g-1];
        end
        mul_stage #(.W(SW)) u_stage (
            .d(pre[g]),
            .q(nxt[g])
        );
    end

    // Flush beats stall beats accept; stall freezes every stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg[k] <= '0;
            end
        end else if (flush_in) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg[k].valid <= 1'b0;
            end
        end else if (!stall_in) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stg[k] <= nxt[k];
            end
        end
    end

    assign ready_out           = ~stall_in;
    assign instr_valid_out     = stg[NUM_STAGES-1].valid;
    assign instr_id_out        = stg[NUM_STAGES-1].id;
    assign program_counter_out = stg[NUM_STAGES-1].pc;
    assign dest_reg_out        = stg[NUM_STAGES-1].rd;
    assign data_result_out     = stg[NUM_STAGES-1].data;
    assign xcpt_fetch_out      = stg[NUM_STAGES-1].xf;
    assign xcpt_decode_out     = stg[NUM_STAGES-1].xd;
    assign xcpt_mul_out        = stg[NUM_STAGES-1].xm;
endmodule

// File: tb/tb_mul_unit.sv
// Directed plus random bench for mul_unit against an age-tagged
// transaction model of the multiply pipeline.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int N = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         instr_valid_in;
    logic [2:0]   instr_id_in;
    logic [31:0]  program_counter_in;
    logic [4:0]   dest_reg_in;
    logic [31:0]  src1_data_in;
    logic [31:0]  src2_data_in;
    fetch_xcpt_t  xcpt_fetch_in;
    decode_xcpt_t xcpt_decode_in;
    logic         stall_in;
    logic         flush_in;
    logic         ready_out;
    logic         instr_valid_out;
    logic [2:0]   instr_id_out;
    logic [31:0]  program_counter_out;
    logic [4:0]   dest_reg_out;
    logic [31:0]  data_result_out;
    fetch_xcpt_t  xcpt_fetch_out;
    decode_xcpt_t xcpt_decode_out;
    mul_xcpt_t    xcpt_mul_out;

    mul_unit #(.NUM_STAGES(N)) dut (
        .clock(clock),
        .reset(reset),
        .instr_valid_in(instr_valid_in),
        .instr_id_in(instr_id_in),
        .program_counter_in(program_counter_in),
        .dest_reg_in(dest_reg_in),
        .src1_data_in(src1_data_in),
        .src2_data_in(src2_data_in),
        .xcpt_fetch_in(xcpt_fetch_in),
        .xcpt_decode_in(xcpt_decode_in),
        .stall_in(stall_in),
        .flush_in(flush_in),
        .ready_out(ready_out),
        .instr_valid_out(instr_valid_out),
        .instr_id_out(instr_id_out),
        .program_counter_out(program_counter_out),
        .dest_reg_out(dest_reg_out),
        .data_result_out(data_result_out),
        .xcpt_fetch_out(xcpt_fetch_out),
        .xcpt_decode_out(xcpt_decode_out),
        .xcpt_mul_out(xcpt_mul_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        bit          fx;
        bit          dx;
        int          age;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_valid_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: an instruction leaves the unit once it has aged past N-1
    task automatic model_edge(input bit v, input bit st, input bit fl);
        ent_t nq[$];
        ent_t e;
        if (fl) begin
            q.delete();
        end else if (!st) begin
            foreach (q[i]) begin
                e = q[i];
                e.age++;
                if (e.age <= N - 1) nq.push_back(e);
            end
            if (v) begin
                e.id  = instr_id_in;
                e.pc  = program_counter_in;
                e.rd  = dest_reg_in;
                e.a   = src1_data_in;
                e.b   = src2_data_in;
                e.fx  = xcpt_fetch_in.valid;
                e.dx  = xcpt_decode_in.valid;
                e.age = 0;
                nq.push_back(e);
            end
            q = nq;
        end
    endtask

    task automatic check_outputs();
        ent_t         e;
        bit           found;
        longint       p;
        bit           ovf;
        logic [31:0]  lo;
        fetch_xcpt_t  xf;
        decode_xcpt_t xd;
        mul_xcpt_t    xm;
        found = 0;
        foreach (q[i]) if (q[i].age == N - 1) begin
            e = q[i];
            found = 1;
        end
        chk("ready", {63'd0, ready_out}, {63'd0, ~stall_in});
        chk("valid", {63'd0, instr_valid_out}, {63'd0, found});
        if (found) begin
            n_valid_seen++;
            p   = longint'($signed(e.a)) * longint'($signed(e.b));
            ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            lo  = p[31:0];
            xf  = '{valid: e.fx, addr_val: e.fx ? e.pc : 32'd0};
            xd  = '{valid: e.dx, addr_val: e.dx ? e.pc : 32'd0};
`ifdef MUL_OVERFLOW_XCPT_EN
            xm = '{xcpt_overflow: ovf && !e.fx && !e.dx, addr_val: e.pc};
`else
            xm = '0;
`endif
            chk("id", 64'(instr_id_out), 64'(e.id));
            chk("pc", 64'(program_counter_out), 64'(e.pc));
            chk("rd", 64'(dest_reg_out), 64'(e.rd));
            if (!e.fx && !e.dx) chk("data", 64'(data_result_out), 64'(lo));
            chk("xf", 64'(xcpt_fetch_out), 64'(xf));
            chk("xd", 64'(xcpt_decode_out), 64'(xd));
            chk("xm", 64'(xcpt_mul_out), 64'(xm));
        end
    endtask

    task automatic step(input bit v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] id,
                        input logic [31:0] pc, input logic [4:0] rd,
                        input bit fx, input bit dx,
                        input bit st, input bit fl);
        instr_valid_in     = v;
        src1_data_in       = a;
        src2_data_in       = b;
        instr_id_in        = id;
        program_counter_in = pc;
        dest_reg_in        = rd;
        xcpt_fetch_in      = '{valid: fx, addr_val: fx ? pc : 32'd0};
        xcpt_decode_in     = '{valid: dx, addr_val: dx ? pc : 32'd0};
        stall_in           = st;
        flush_in           = fl;
        @(posedge clock);
        model_edge(v, st, fl);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_v"}, {63'd0, instr_valid_out}, 64'd0);
        chk({tag, "_d"}, 64'(data_result_out), 64'd0);
        chk({tag, "_id"}, 64'(instr_id_out), 64'd0);
        chk({tag, "_pc"}, 64'(program_counter_out), 64'd0);
        chk({tag, "_rd"}, 64'(dest_reg_out), 64'd0);
        chk({tag, "_xm"}, 64'(xcpt_mul_out), 64'd0);
        chk({tag, "_xd"}, 64'(xcpt_decode_out), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        instr_valid_in = 0;
        instr_id_in = 0;
        program_counter_in = 0;
        dest_reg_in = 0;
        src1_data_in = 0;
        src2_data_in = 0;
        xcpt_fetch_in = '0;
        xcpt_decode_in = '0;
        stall_in = 0;
        flush_in = 0;
        #12;
        check_zero("rst");
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        check_zero("post_rst");

        // Single request, 7 * -6
        step(1, 7, -32'sd6, 2, 32'h100, 5'd3, 0, 0, 0, 0);
        idle(N + 1);

        // Back-to-back, third overflows
        step(1, 2, 3, 1, 32'h200, 5'd1, 0, 0, 0, 0);
        step(1, 4, 5, 2, 32'h204, 5'd2, 0, 0, 0, 0);
        step(1, 32'h10000, 32'h10000, 3, 32'h208, 5'd4, 0, 0, 0, 0);
        idle(N + 1);

        // Stall three cycles with one request in flight
        step(1, -32'sd9, -32'sd9, 4, 32'h300, 5'd7, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(N + 1);

        // Stall while result is sitting on the outputs
        step(1, 11, 13, 5, 32'h340, 5'd8, 0, 0, 0, 0);
        idle(N - 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Flush two in flight plus a same-cycle request
        seen = n_valid_seen;
        step(1, 3, 3, 1, 32'h400, 5'd1, 0, 0, 0, 0);
        step(1, 5, 5, 2, 32'h404, 5'd2, 0, 0, 0, 0);
        step(1, 6, 6, 3, 32'h408, 5'd3, 0, 0, 0, 1);
        idle(N + 2);
        chk("flush_none", 64'(n_valid_seen - seen), 64'd0);

        // Decode exception suppresses overflow
        step(1, 32'h7fffffff, 2, 6, 32'h500, 5'd9, 0, 1, 0, 0);
        step(1, 32'h7fffffff, 2, 7, 32'h504, 5'd9, 1, 0, 0, 0);
        step(1, 32'h7fffffff, 2, 0, 32'h508, 5'd9, 0, 0, 0, 0);
        idle(N + 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: ra = $urandom_range(15);
                1: ra = -$urandom_range(15);
                2: ra = $urandom_range(1) ? 32'h80000000 : 32'h7fffffff;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(70000));
            step($urandom_range(3) != 0, ra, rb, 3'($urandom),
                 $urandom, 5'($urandom),
                 $urandom_range(15) == 0, $urandom_range(15) == 0,
                 $urandom_range(4) == 0, $urandom_range(19) == 0);
        end
        idle(N + 1);

        // Asynchronous reset with four in flight
        for (int i = 0; i < 4; i++)
            step(1, i + 2, 100, 3'(i), 32'h600 + 4 * i, 5'(i), 0, 0, 0, 0);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check_zero("async_rst");
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        check_zero("rel");
        step(1, -32'sd3, 1000, 5, 32'h700, 5'd6, 0, 0, 0, 0);
        idle(N + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle integer multiply unit. Sits between decode/issue and the reorder buffer (ROB) write port.
- Accepts one multiply request per cycle. Computes the signed product and overflow exception in the first stage.
- Carries the result through NUM_STAGES registered stages; each stage is a pass-through stage instance followed by a pipeline register.
- Supports a global stall (ROB backpressure) and a flush (exception/branch recovery).

Parameters:
- NUM_STAGES, 5, total pipeline depth in registers; legal range 2..8.
- DATA_W, 32, operand/result width (REG_FILE_DATA_RANGE).
- ROB_ID_W, 3, instruction ID width (ROB_ID_RANGE).
- PC_W, 32, program counter width.
- RF_ADDR_W, 5, destination register address width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid_in  in  1  multiply request valid.
- instr_id_in  in  ROB_ID_W  ROB tag.
- program_counter_in  in  PC_W  PC of instruction.
- dest_reg_in  in  RF_ADDR_W  destination register.
- src1_data_in  in  DATA_W  operand A, signed.
- src2_data_in  in  DATA_W  operand B, signed.
- xcpt_fetch_in  in  fetch_xcpt_t  upstream fetch exception.
- xcpt_decode_in  in  decode_xcpt_t  upstream decode exception.
- stall_in  in  1  ROB cannot accept; freeze pipeline.
- flush_in  in  1  kill all in-flight instructions.
- ready_out  out  1  unit can accept this cycle (= !stall_in).
- instr_valid_out  out  1  result valid toward ROB.
- instr_id_out  out  ROB_ID_W  ROB tag.
- program_counter_out  out  PC_W  PC.
- dest_reg_out  out  RF_ADDR_W  destination register.
- data_result_out  out  DATA_W  low DATA_W bits of product.
- xcpt_fetch_out  out  fetch_xcpt_t  forwarded.
- xcpt_decode_out  out  decode_xcpt_t  forwarded.
- xcpt_mul_out  out  mul_xcpt_t  {xcpt_overflow, addr_val=PC}.

Behaviour:
- Reset (async, active-high): all stage valid bits, data, IDs, PCs and exception fields clear to 0. All outputs read 0 while reset is asserted and on the first cycle after release.
- Accept: on a rising edge with instr_valid_in=1 and stall_in=0 and flush_in=0, stage 0 captures the request.
- Stage 0 computes:
  - prod = signed(src1) * signed(src2), 2*DATA_W bits.
  - data_result = prod[DATA_W-1:0].
  - overflow = (prod[2*DATA_W-1:DATA_W-1] not all zeros and not all ones).
- If xcpt_fetch_in or xcpt_decode_in has its valid flag set, no multiply result is required: the exceptions are forwarded and xcpt_mul.xcpt_overflow is forced to 0.
- Stages 1..NUM_STAGES-1 copy the previous stage unchanged. Outputs are driven directly from the final stage register.
- Latency: a request accepted at edge t appears on the outputs after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles of occupancy with no stall. Throughput is 1 per cycle.
- Stall (stall_in=1, flush_in=0): every stage register, including the outputs, holds its value. No new request is accepted. instr_valid_out stays asserted if it was set; the ROB consumes the result on the first non-stalled edge.
- Bubbles are not collapsed during a stall.
- Flush (flush_in=1): on that edge all stage valid bits clear; data fields may retain stale values. The same-cycle input is dropped. Flush has priority over stall and over accept.
- Reset mid-operation: in-flight instructions are discarded silently.
- Overflow with a valid input sets xcpt_mul.xcpt_overflow=1 and addr_val=PC. data_result still carries the low bits.
- Fields of invalid stages are don't-care, but must not generate instr_valid_out.

Optional Feature:
- MUL_OVERFLOW_XCPT_EN defined: overflow detection as above; xcpt_mul_out is driven from the pipeline.
- Not defined: overflow logic is omitted; xcpt_mul_out is constant 0; the product is still truncated to DATA_W.

Test Plan:
- Reset then single request src1=7, src2=-6, id=2, PC=0x100, NUM_STAGES=5 -> instr_valid_out=1 exactly 5 cycles later, data_result_out=0xFFFFFFD6, id=2, PC=0x100, overflow=0.
- Back-to-back 3 requests (2*3, 4*5, 0x10000*0x10000) -> three consecutive valid outputs 6, 20, 0. Third has overflow=1 with MUL_OVERFLOW_XCPT_EN, 0 without.
- Request in flight, stall_in=1 for 3 cycles at cycle 2 -> output appears at cycle 8, values unchanged, no duplicate or lost instruction.
- Two requests in flight, flush_in=1 at cycle 3 with a simultaneous new request -> instr_valid_out never asserts for any of the three.
- xcpt_decode_in.valid=1 with src1=0x7FFFFFFF, src2=2 -> decode exception forwarded, xcpt_overflow=0.
- Assert reset asynchronously (between edges) with 4 instructions in flight -> all outputs 0 immediately. After release, a new request produces a correct result with no stale valid.
